// File: rtl/sblk_inst_sched_if.sv
// Host instruction stream and superblock-row dispatch signals of the instruction scheduler.
// The master side is the host/controller plus the superblock row; the slave side is the scheduler.
interface sblk_inst_sched_if #(
    parameter int N_ROW    = 3,
    parameter int WID_INST = 14,
    parameter int WID_ROW  = (N_ROW > 1) ? $clog2(N_ROW) : 1
);
    logic [WID_INST-1:0]       host_inst;
    logic [WID_ROW-1:0]        host_row;
    logic                      host_vld;
    logic                      host_rdy;
    logic                      flush;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic [N_ROW-1:0]          status_sblk;
    logic [N_ROW-1:0]          row_done;
    logic                      all_idle;
    logic [N_ROW-1:0]          err_timeout;

    modport master (
        output host_inst, host_row, host_vld, flush, status_sblk,
        input  host_rdy, inst_data, inst_en, row_done, all_idle, err_timeout
    );

    modport slave (
        input  host_inst, host_row, host_vld, flush, status_sblk,
        output host_rdy, inst_data, inst_en, row_done, all_idle, err_timeout
    );
endinterface

// File: rtl/sblk_inst_sched.sv
// Instruction scheduler: per-row FIFOs fed from one tagged host stream, and a per-row
// issue/ack/done FSM that dispatches one instruction at a time to each superblock row.
module sblk_inst_sched #(
    parameter int N_ROW    = 3,
    parameter int WID_INST = 14,
    parameter int QDEPTH   = 4,
    parameter int WID_ROW  = (N_ROW > 1) ? $clog2(N_ROW) : 1,
    parameter int ACK_TO   = 15
) (
    input logic              clk_l,
    input logic              rst,
    sblk_inst_sched_if.slave bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TO + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    logic                rst_q;
    logic [WID_INST-1:0] mem       [N_ROW][QDEPTH];
    logic [PW-1:0]       wr_ptr    [N_ROW];
    logic [PW-1:0]       rd_ptr    [N_ROW];
    logic [CW-1:0]       count     [N_ROW];
    logic [CW-1:0]       count_nxt [N_ROW];
    state_t              state     [N_ROW];
    state_t              state_nxt [N_ROW];
    logic [TW-1:0]       timer     [N_ROW];
    logic [TW-1:0]       timer_nxt [N_ROW];
    logic [N_ROW-1:0]    full, empty, push, pop;
    logic [N_ROW-1:0]    inst_en_d, row_done_d, timeout_d;
    logic                row_full, all_idle_d;

    // Holds host_rdy low through the first edge after reset release.
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) rst_q <= 1'b1;
        else     rst_q <= 1'b0;
    end

    // Out-of-range tags never look full, so they are accepted and dropped.
    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < N_ROW; r++)
            if (bus.host_row == WID_ROW'(r)) row_full = full[r];
        bus.host_rdy = !rst_q && !bus.flush && !row_full;
    end

    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            full[r]      = (count[r] == CW'(QDEPTH));
            empty[r]     = (count[r] == '0);
            push[r]      = bus.host_vld && bus.host_rdy && (bus.host_row == WID_ROW'(r));
            pop[r]       = (state[r] == IDLE) && !empty[r];
            count_nxt[r] = bus.flush ? '0 : count[r] + CW'(push[r]) - CW'(pop[r]);
        end
    end

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_ROW; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                count[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                count[r] <= count_nxt[r];
                if (bus.flush) begin
                    wr_ptr[r] <= '0;
                    rd_ptr[r] <= '0;
                end else begin
                    if (push[r]) wr_ptr[r] <= wr_ptr[r] + PW'(1);
                    if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_l) begin
        for (int r = 0; r < N_ROW; r++)
            if (push[r]) mem[r][wr_ptr[r]] <= bus.host_inst;
    end

    // FSM state register
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N_ROW; r++) begin
                state[r] <= IDLE;
                timer[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N_ROW; r++) begin
                state[r] <= state_nxt[r];
                timer[r] <= timer_nxt[r];
            end
        end
    end

    // FSM next state; the ack timer expires on the edge that would take it to ACK_TO
    always_comb begin
        for (int r = 0; r < N_ROW; r++) begin
            state_nxt[r] = state[r];
            timer_nxt[r] = timer[r];
            case (state[r])
                IDLE:      if (!empty[r]) state_nxt[r] = ISSUE;
                ISSUE: begin
                    state_nxt[r] = WAIT_ACK;
                    timer_nxt[r] = '0;
                end
                WAIT_ACK: begin
                    if (bus.status_sblk[r])                  state_nxt[r] = WAIT_DONE;
                    else if (timer[r] == TW'(ACK_TO - 1))    state_nxt[r] = IDLE;
                    else                                     timer_nxt[r] = timer[r] + TW'(1);
                end
                WAIT_DONE: if (!bus.status_sblk[r]) state_nxt[r] = IDLE;
                default:   state_nxt[r] = IDLE;
            endcase
        end
    end

    // FSM outputs, registered below so inst_en coincides with ISSUE
    always_comb begin
        all_idle_d = 1'b1;
        for (int r = 0; r < N_ROW; r++) begin
            inst_en_d[r]  = pop[r];
            timeout_d[r]  = (state[r] == WAIT_ACK) && !bus.status_sblk[r] &&
                            (timer[r] == TW'(ACK_TO - 1));
            row_done_d[r] = timeout_d[r] || ((state[r] == WAIT_DONE) && !bus.status_sblk[r]);
            if (count_nxt[r] != '0 || state_nxt[r] != IDLE) all_idle_d = 1'b0;
        end
    end

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            bus.inst_en     <= '0;
            bus.row_done    <= '0;
            bus.err_timeout <= '0;
            bus.all_idle    <= 1'b1;
            bus.inst_data   <= '0;
        end else begin
            bus.inst_en     <= inst_en_d;
            bus.row_done    <= row_done_d;
            bus.err_timeout <= bus.err_timeout | timeout_d;
            bus.all_idle    <= all_idle_d;
            for (int r = 0; r < N_ROW; r++)
                if (pop[r]) bus.inst_data[r*WID_INST +: WID_INST] <= mem[r][rd_ptr[r]];
        end
    end
endmodule

// File: tb/tb_sblk_inst_sched.sv
// Bench for sblk_inst_sched: directed scenarios plus random traffic, with a per-row
// superblock model and an in-order queue scoreboard of expected issues and done timing.
module tb_sblk_inst_sched;
    localparam int N_ROW    = 3;
    localparam int WID_INST = 14;
    localparam int QDEPTH   = 4;
    localparam int WID_ROW  = 2;
    localparam int ACK_TO   = 15;

    logic clk_l = 1'b0;
    logic rst;
    always #5 clk_l = ~clk_l;

    sblk_inst_sched_if #(.N_ROW(N_ROW), .WID_INST(WID_INST), .WID_ROW(WID_ROW)) bus();

    sblk_inst_sched #(
        .N_ROW(N_ROW), .WID_INST(WID_INST), .QDEPTH(QDEPTH), .WID_ROW(WID_ROW), .ACK_TO(ACK_TO)
    ) dut (
        .clk_l (clk_l),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;

    logic [WID_INST-1:0] exp_q [N_ROW][$];
    logic [WID_INST-1:0] exp_d;
    int  ack_dly  [N_ROW] = '{2, 2, 2};
    int  busy_len [N_ROW] = '{3, 3, 3};
    bit  hold_rel [N_ROW] = '{0, 0, 0};
    bit  rand_cfg = 1'b0;
    int  sb_phase [N_ROW] = '{0, 0, 0};
    int  sb_cnt   [N_ROW] = '{0, 0, 0};
    int  en_cnt   [N_ROW] = '{0, 0, 0};
    int  done_cnt [N_ROW] = '{0, 0, 0};
    int  acc_cnt  [N_ROW] = '{0, 0, 0};
    int  en_cyc   [N_ROW] = '{-1, -1, -1};
    int  done_cyc [N_ROW] = '{-1, -1, -1};
    int  err_cyc  [N_ROW] = '{-1, -1, -1};
    int  exp_done [N_ROW] = '{-1, -1, -1};

    initial forever begin
        @(posedge clk_l);
        cyc++;
    end

    // Superblock rows plus scoreboard, evaluated once per cycle away from the active edge
    initial begin
        bus.status_sblk = '0;
        forever begin
            @(negedge clk_l);
            if (rst) begin
                bus.status_sblk = '0;
                for (int r = 0; r < N_ROW; r++) sb_phase[r] = 0;
            end else begin
                for (int r = 0; r < N_ROW; r++) begin
                    if (sb_phase[r] == 1) begin
                        sb_cnt[r]--;
                        if (sb_cnt[r] == 0) begin
                            bus.status_sblk[r] = 1'b1;
                            sb_phase[r] = 2;
                            sb_cnt[r] = busy_len[r];
                        end
                    end else if (sb_phase[r] == 2) begin
                        if (sb_cnt[r] < 0) begin
                            if (hold_rel[r]) begin
                                bus.status_sblk[r] = 1'b0;
                                sb_phase[r] = 0;
                                hold_rel[r] = 1'b0;
                            end
                        end else begin
                            sb_cnt[r]--;
                            if (sb_cnt[r] == 0) begin
                                bus.status_sblk[r] = 1'b0;
                                sb_phase[r] = 0;
                            end
                        end
                    end
                    if (bus.inst_en[r]) begin
                        en_cnt[r]++;
                        en_cyc[r] = cyc;
                        if (rand_cfg) begin
                            ack_dly[r]  = int'($urandom_range(1, 4));
                            busy_len[r] = int'($urandom_range(1, 6));
                        end
                        n_checks++;
                        if (exp_q[r].size() == 0)
                            $display("FAIL issue_order row%0d: got %0h with nothing queued", r, bus.inst_data[r*WID_INST +: WID_INST]);
                        else begin
                            exp_d = exp_q[r].pop_front();
                            if (bus.inst_data[r*WID_INST +: WID_INST] !== exp_d)
                                $display("FAIL issue_data row%0d: got %0h want %0h", r, bus.inst_data[r*WID_INST +: WID_INST], exp_d);
                            else n_pass++;
                        end
                        if (ack_dly[r] < 0)       exp_done[r] = cyc + 1 + ACK_TO;
                        else if (busy_len[r] < 0) exp_done[r] = -1;
                        else                      exp_done[r] = cyc + ack_dly[r] + busy_len[r] + 1;
                        if (ack_dly[r] > 0) begin
                            sb_phase[r] = 1;
                            sb_cnt[r] = ack_dly[r];
                        end
                    end
                    if (bus.row_done[r]) begin
                        done_cnt[r]++;
                        done_cyc[r] = cyc;
                        if (exp_done[r] >= 0) begin
                            n_checks++;
                            if (cyc !== exp_done[r])
                                $display("FAIL done_time row%0d: got cycle %0d want %0d", r, cyc, exp_done[r]);
                            else n_pass++;
                        end
                    end
                    if (bus.err_timeout[r] && err_cyc[r] < 0) err_cyc[r] = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_l);
        #2;
    endtask

    task automatic push(input int row, input logic [WID_INST-1:0] d, output bit ok);
        bus.host_row  = WID_ROW'(row);
        bus.host_inst = d;
        bus.host_vld  = 1'b1;
        #1 ok = bus.host_rdy;
        if (ok && row < N_ROW) begin
            exp_q[row].push_back(d);
            acc_cnt[row]++;
        end
        tick(1);
        bus.host_vld = 1'b0;
        last_acc = cyc;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (bus.all_idle) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL %s_idle: all_idle=%0b after %0d cycles, want 1", name, bus.all_idle, budget);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.host_vld = 1'b0; bus.host_row = '0; bus.host_inst = '0; bus.flush = 1'b0;
        #1;
        n_checks++; if (bus.host_rdy !== 1'b0) $display("FAIL rst_host_rdy: got %0b want 0", bus.host_rdy); else n_pass++;
        n_checks++; if (bus.inst_data !== '0) $display("FAIL rst_inst_data: got %0h want 0", bus.inst_data); else n_pass++;
        n_checks++; if (bus.inst_en !== '0) $display("FAIL rst_inst_en: got %0b want 0", bus.inst_en); else n_pass++;
        n_checks++; if (bus.row_done !== '0) $display("FAIL rst_row_done: got %0b want 0", bus.row_done); else n_pass++;
        n_checks++; if (bus.all_idle !== 1'b1) $display("FAIL rst_all_idle: got %0b want 1", bus.all_idle); else n_pass++;
        n_checks++; if (bus.err_timeout !== '0) $display("FAIL rst_err: got %0b want 0", bus.err_timeout); else n_pass++;
        tick(2);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.host_rdy !== 1'b0) $display("FAIL rdy_at_release: got %0b want 0", bus.host_rdy); else n_pass++;
        tick(1);
        n_checks++; if (bus.host_rdy !== 1'b1) $display("FAIL rdy_after_release: got %0b want 1", bus.host_rdy); else n_pass++;
    endtask

    task automatic test_single_issue;
        bit ok;
        int k, en0 = en_cnt[1], dn0 = done_cnt[1];
        ack_dly[1] = 2; busy_len[1] = 5;
        push(1, 14'h1A5, ok);
        k = last_acc;
        n_checks++; if (ok !== 1'b1) $display("FAIL single_accept: got %0b want 1", ok); else n_pass++;
        tick(1);
        n_checks++; if (bus.inst_en !== 3'b010) $display("FAIL single_inst_en: got %b want 010", bus.inst_en); else n_pass++;
        n_checks++; if (bus.inst_data[WID_INST +: WID_INST] !== 14'h1A5) $display("FAIL single_slice: got %0h want 1a5", bus.inst_data[WID_INST +: WID_INST]); else n_pass++;
        n_checks++; if (en_cyc[1] - k !== 1) $display("FAIL single_latency: got %0d want 1", en_cyc[1] - k); else n_pass++;
        tick(1);
        n_checks++; if (bus.inst_en !== 3'b000) $display("FAIL single_strobe_width: got %b want 000", bus.inst_en); else n_pass++;
        wait_idle(40, "single");
        n_checks++; if (done_cnt[1] - dn0 !== 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt[1] - dn0); else n_pass++;
        n_checks++; if (en_cnt[1] - en0 !== 1) $display("FAIL single_en_cnt: got %0d want 1", en_cnt[1] - en0); else n_pass++;
        n_checks++; if (bus.inst_data[WID_INST +: WID_INST] !== 14'h1A5) $display("FAIL single_slice_hold: got %0h want 1a5", bus.inst_data[WID_INST +: WID_INST]); else n_pass++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int en0 = en_cnt[0];
        ack_dly[0] = 1; busy_len[0] = -1;
        for (int i = 0; i < 5; i++) begin
            push(0, WID_INST'($urandom), ok);
            n_checks++; if (ok !== 1'b1) $display("FAIL bp_accept%0d: got %0b want 1", i, ok); else n_pass++;
        end
        bus.host_row = 2'd0;
        #1;
        n_checks++; if (bus.host_rdy !== 1'b0) $display("FAIL bp_rdy_row0: got %0b want 0", bus.host_rdy); else n_pass++;
        bus.host_row = 2'd2;
        #1;
        n_checks++; if (bus.host_rdy !== 1'b1) $display("FAIL bp_rdy_row2: got %0b want 1", bus.host_rdy); else n_pass++;
        tick(1);
        push(0, 14'h3FFF, ok);
        n_checks++; if (ok !== 1'b0) $display("FAIL bp_full_reject: got %0b want 0", ok); else n_pass++;
        n_checks++; if (en_cnt[0] - en0 !== 1) $display("FAIL bp_held_issues: got %0d want 1", en_cnt[0] - en0); else n_pass++;
        busy_len[0] = 3;
        hold_rel[0] = 1'b1;
        wait_idle(120, "bp");
        n_checks++; if (en_cnt[0] - en0 !== 5) $display("FAIL bp_drain_cnt: got %0d want 5", en_cnt[0] - en0); else n_pass++;
        n_checks++; if (exp_q[0].size() !== 0) $display("FAIL bp_leftover: got %0d want 0", exp_q[0].size()); else n_pass++;
    endtask

    task automatic test_parallel;
        bit ok;
        int dn[N_ROW];
        for (int r = 0; r < N_ROW; r++) dn[r] = done_cnt[r];
        ack_dly  = '{1, 2, 3};
        busy_len = '{2, 4, 3};
        for (int r = 0; r < N_ROW; r++) push(r, WID_INST'(14'h100 + r), ok);
        wait_idle(40, "par");
        n_checks++; if (en_cyc[1] - en_cyc[0] !== 1) $display("FAIL par_gap01: got %0d want 1", en_cyc[1] - en_cyc[0]); else n_pass++;
        n_checks++; if (en_cyc[2] - en_cyc[1] !== 1) $display("FAIL par_gap12: got %0d want 1", en_cyc[2] - en_cyc[1]); else n_pass++;
        for (int r = 0; r < N_ROW; r++) begin
            n_checks++; if (done_cnt[r] - dn[r] !== 1) $display("FAIL par_done_row%0d: got %0d want 1", r, done_cnt[r] - dn[r]); else n_pass++;
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int e1, en0 = en_cnt[2], dn0 = done_cnt[2];
        ack_dly[2] = -1;
        n_checks++; if (bus.err_timeout !== 3'b000) $display("FAIL to_err_before: got %b want 000", bus.err_timeout); else n_pass++;
        push(2, 14'h2AA, ok);
        push(2, 14'h155, ok);
        e1 = en_cyc[2];
        for (int i = 0; i < 40 && err_cyc[2] < 0; i++) tick(1);
        n_checks++; if (err_cyc[2] - e1 !== ACK_TO + 1) $display("FAIL to_err_time: got %0d want %0d", err_cyc[2] - e1, ACK_TO + 1); else n_pass++;
        wait_idle(60, "to");
        n_checks++; if (en_cnt[2] - en0 !== 2) $display("FAIL to_next_issue: got %0d want 2", en_cnt[2] - en0); else n_pass++;
        n_checks++; if (done_cnt[2] - dn0 !== 2) $display("FAIL to_done_cnt: got %0d want 2", done_cnt[2] - dn0); else n_pass++;
        n_checks++; if (bus.err_timeout !== 3'b100) $display("FAIL to_err_sticky: got %b want 100", bus.err_timeout); else n_pass++;
        ack_dly[2] = 2; busy_len[2] = 2;
    endtask

    task automatic test_flush_badtag;
        bit ok;
        int en0 = en_cnt[0], en1 = en_cnt[1], dn0 = done_cnt[0];
        ack_dly[0] = 1; busy_len[0] = -1;
        push(0, 14'h011, ok);
        push(0, 14'h022, ok);
        push(0, 14'h033, ok);
        tick(3);
        bus.flush = 1'b1;
        bus.host_row = 2'd1; bus.host_inst = 14'h0F0; bus.host_vld = 1'b1;
        #1;
        n_checks++; if (bus.host_rdy !== 1'b0) $display("FAIL flush_rdy: got %0b want 0", bus.host_rdy); else n_pass++;
        for (int r = 0; r < N_ROW; r++) exp_q[r].delete();
        tick(1);
        bus.flush = 1'b0; bus.host_vld = 1'b0;
        busy_len[0] = 2;
        hold_rel[0] = 1'b1;
        wait_idle(40, "flush");
        n_checks++; if (en_cnt[0] - en0 !== 1) $display("FAIL flush_issues: got %0d want 1", en_cnt[0] - en0); else n_pass++;
        n_checks++; if (done_cnt[0] - dn0 !== 1) $display("FAIL flush_inflight_done: got %0d want 1", done_cnt[0] - dn0); else n_pass++;
        n_checks++; if (en_cnt[1] - en1 !== 0) $display("FAIL flush_blocked_push: got %0d want 0", en_cnt[1] - en1); else n_pass++;
        push(3, 14'h3C3, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL badtag_accept: got %0b want 1", ok); else n_pass++;
        tick(5);
        n_checks++; if (en_cnt[0] + en_cnt[1] + en_cnt[2] !== en0 + 1 + en1 + en_cnt[2])
            $display("FAIL badtag_issue: got %0d issues want none", en_cnt[0] + en_cnt[1] - en0 - 1 - en1); else n_pass++;
        n_checks++; if (bus.all_idle !== 1'b1) $display("FAIL badtag_idle: got %0b want 1", bus.all_idle); else n_pass++;
    endtask

    task automatic test_random;
        bit ok;
        int en0[N_ROW], dn0[N_ROW], ac0[N_ROW];
        for (int r = 0; r < N_ROW; r++) begin
            en0[r] = en_cnt[r]; dn0[r] = done_cnt[r]; ac0[r] = acc_cnt[r];
        end
        rand_cfg = 1'b1;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 2) != 0) push(int'($urandom_range(0, 3)), WID_INST'($urandom), ok);
            else tick(1);
        end
        wait_idle(400, "rand");
        rand_cfg = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            n_checks++; if (en_cnt[r] - en0[r] !== acc_cnt[r] - ac0[r])
                $display("FAIL rand_issues_row%0d: got %0d want %0d", r, en_cnt[r] - en0[r], acc_cnt[r] - ac0[r]); else n_pass++;
            n_checks++; if (done_cnt[r] - dn0[r] !== en_cnt[r] - en0[r])
                $display("FAIL rand_done_row%0d: got %0d want %0d", r, done_cnt[r] - dn0[r], en_cnt[r] - en0[r]); else n_pass++;
        end
    endtask

    task automatic test_reset_midstream;
        bit ok;
        int en0;
        ack_dly[0] = 1; busy_len[0] = -1;
        push(0, 14'h0AB, ok);
        push(0, 14'h0CD, ok);
        tick(3);
        n_checks++; if (bus.all_idle !== 1'b0) $display("FAIL mid_busy: got %0b want 0", bus.all_idle); else n_pass++;
        en0 = en_cnt[0];
        rst = 1'b1;
        #1;
        n_checks++; if (bus.all_idle !== 1'b1) $display("FAIL mid_all_idle: got %0b want 1", bus.all_idle); else n_pass++;
        n_checks++; if (bus.err_timeout !== '0) $display("FAIL mid_err_clear: got %b want 000", bus.err_timeout); else n_pass++;
        n_checks++; if (bus.inst_data !== '0) $display("FAIL mid_inst_data: got %0h want 0", bus.inst_data); else n_pass++;
        n_checks++; if (bus.inst_en !== '0) $display("FAIL mid_inst_en: got %b want 000", bus.inst_en); else n_pass++;
        for (int r = 0; r < N_ROW; r++) begin
            exp_q[r].delete();
            hold_rel[r] = 1'b0;
        end
        busy_len[0] = 3;
        tick(1);
        rst = 1'b0;
        tick(1);
        n_checks++; if (bus.host_rdy !== 1'b1) $display("FAIL mid_rdy: got %0b want 1", bus.host_rdy); else n_pass++;
        tick(6);
        n_checks++; if (en_cnt[0] !== en0) $display("FAIL mid_fifo_empty: got %0d issues want 0", en_cnt[0] - en0); else n_pass++;
        n_checks++; if (bus.all_idle !== 1'b1) $display("FAIL mid_idle_after: got %0b want 1", bus.all_idle); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_issue();
        test_backpressure();
        test_parallel();
        test_timeout();
        test_flush_badtag();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sblk_inst_sched.md
Name: sblk_inst_sched

Overview:
Instruction scheduler for a row of superblocks. Accepts a single tagged instruction stream from the host/controller and buffers it in per-row FIFOs. Dispatches one instruction at a time to each row through the inst_data/inst_en interface, then tracks each row's status_sblk busy/done handshake before issuing the next one. Sits between the top-level controller and the superblock row; all rows run independently and in parallel.

Parameters:
N_ROW, 3, number of superblock rows served
WID_INST, 14, instruction width (TN+TM+TP+LN+LP fields, opaque here)
QDEPTH, 4, per-row FIFO depth (power of 2, >=2)
WID_ROW, $clog2(N_ROW) (min 1), row tag width
ACK_TO, 15, max cycles to wait for status_sblk rise after issue

Ports:
clk_l  input  1  sole clock
rst  input  1  asynchronous, active-high reset
host_inst  input  WID_INST  instruction payload
host_row  input  WID_ROW  destination row
host_vld  input  1  host offers instruction
host_rdy  output  1  scheduler can accept
flush  input  1  synchronous; discard queued (not in-flight) instructions
inst_data  output  WID_INST*N_ROW  row r payload at [r*WID_INST +: WID_INST]
inst_en  output  N_ROW  one-cycle issue strobe per row
status_sblk  input  N_ROW  row busy (high while executing)
row_done  output  N_ROW  one-cycle pulse when a row completes an instruction
all_idle  output  1  all FIFOs empty and all rows in IDLE
err_timeout  output  N_ROW  sticky: row never acknowledged an issue

Behaviour:
- Reset: host_rdy=0, inst_data=0, inst_en=0, row_done=0, all_idle=1, err_timeout=0; FIFOs empty; all FSMs IDLE. host_rdy rises the cycle after reset deasserts. Mid-operation reset aborts everything immediately, with no drain.
- host_rdy = !rst_q && !flush && (host_row >= N_ROW || !full[host_row]); combinational on host_row. Accept when host_vld && host_rdy at a rising edge.
- host_row >= N_ROW: accepted and silently dropped.
- FIFO per row: depth QDEPTH, registered count, pointers wrap modulo QDEPTH. Simultaneous push and pop on a full FIFO is not accepted (host_rdy uses full only; no bypass). Push and pop in the same cycle on a non-full FIFO keeps count unchanged.
- Per-row FSM, states IDLE, ISSUE, WAIT_ACK, WAIT_DONE:
  - IDLE: if FIFO not empty, go to ISSUE, pop the head, and register it into inst_data slice r.
  - ISSUE: inst_en[r]=1 for exactly this cycle; go to WAIT_ACK with timer=0.
  - WAIT_ACK: if status_sblk[r]=1, go to WAIT_DONE. Else timer++. When timer==ACK_TO, set err_timeout[r], pulse row_done[r], and go to IDLE.
  - WAIT_DONE: when status_sblk[r]=0, pulse row_done[r] and go to IDLE.
- inst_data slice holds its value after issue until the next issue; it is not cleared.
- Latency: instruction accepted at edge k into an empty FIFO of an IDLE row gives inst_en high in the cycle after edge k+1 (sampled by the sblk at edge k+2). Back-to-back issue spacing to a row is at least 4 cycles (ISSUE, ACK, DONE, IDLE).
- row_done and inst_en are registered. Different rows issue in the same cycle freely.
- flush: at the edge where it is high, all FIFOs are emptied. In-flight FSM states are unaffected and complete normally. A push in the same cycle is blocked (host_rdy=0).
- all_idle registered: 1 when every count==0 and every FSM==IDLE.
- err_timeout clears only on rst.

Test Plan:
- Reset then idle: rst pulse mid-stream with row0 in WAIT_DONE -> next cycle inst_en=0, all_idle=1, FIFOs empty, err_timeout=0.
- Single issue: push 14'h1A5 to row 1 at edge k, sblk model raises status 2 cycles after inst_en and holds 5 cycles -> inst_en[1] high in cycle k+2 with slice 1 = 14'h1A5, row_done[1] one pulse, all_idle returns to 1.
- Backpressure: push 5 instructions to row 0 with the row held busy -> first issued and 4 queued, host_rdy=0 for host_row=0 but 1 for host_row=2; order preserved on drain.
- Parallel rows: one instruction each to rows 0,1,2 on consecutive edges -> three inst_en strobes on consecutive cycles, independent row_done pulses.
- Timeout: status_sblk[2] tied 0 -> err_timeout[2] set 15 cycles after WAIT_ACK entry, row_done[2] pulses, next queued instruction still issues.
- Flush and bad tag: queue 3 to row 0 while busy, then assert flush -> remaining 2 discarded, in-flight completes. Push with host_row=3 -> accepted, no inst_en.
